// File: rtl/rdoq_rate_scheduler.sv
// RDOQ rate scheduler: walks one coefficient group through fetch -> accumulate -> collect,
// reporting each per-coefficient rate and a saturating CG rate total.
module rdoq_rate_scheduler #(
  parameter int NUM_COEFF = 16,
  parameter int RATE_W    = 32,
  parameter int TOT_W     = 36
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cg_start,
  input  logic [$clog2(NUM_COEFF+1)-1:0] cg_num_coeff,
  input  logic                           cg_abort,
  output logic                           coef_req,
  output logic [$clog2(NUM_COEFF)-1:0]   coef_idx,
  input  logic                           coef_vld,
  input  logic [RATE_W-1:0]              coef_sign_bits,
  input  logic [RATE_W-1:0]              coef_suffix_bits,
  input  logic [RATE_W-1:0]              coef_ctx_bits,
  input  logic [1:0]                     coef_level_case,
  output logic                           acc_start,
  output logic [RATE_W-1:0]              acc_sign_bit_cost,
  output logic [RATE_W-1:0]              acc_suffix_bits,
  output logic [RATE_W-1:0]              acc_context_bits,
  output logic [1:0]                     acc_level_case,
  input  logic [RATE_W-1:0]              acc_irate,
  input  logic                           acc_done,
  output logic                           rate_vld,
  output logic [$clog2(NUM_COEFF)-1:0]   rate_idx,
  output logic [RATE_W-1:0]              rate_val,
  output logic [TOT_W-1:0]               cg_rate_total,
  output logic                           cg_sat,
  output logic                           cg_done,
  output logic                           busy
);

  localparam int NW = $clog2(NUM_COEFF+1);
  localparam int IW = $clog2(NUM_COEFF);
  localparam int SW = TOT_W + 1;
  localparam logic [NW-1:0] MAX_N = NW'(NUM_COEFF);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_LAUNCH,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t        state;
  logic [NW-1:0] num_q;
  logic [IW-1:0] idx;
  logic [NW-1:0] n_clamp;
  logic          last_coef;
  logic [SW-1:0] sum_ext;

  always_comb begin
    n_clamp   = (cg_num_coeff > MAX_N) ? MAX_N : cg_num_coeff;
    last_coef = ((NW'(idx) + NW'(1)) == num_q);
    // one extra bit catches overflow; a saturated total stays all-ones
    sum_ext   = {1'b0, cg_rate_total} + SW'(acc_irate);
  end

  // handshake strobes are gated by abort so they drop in the abort cycle itself
  assign coef_req  = (state == S_REQ)    && !cg_abort;
  assign acc_start = (state == S_LAUNCH) && !cg_abort;
  assign cg_done   = (state == S_FINISH) && !cg_abort;
  assign busy      = (state != S_IDLE);
  assign coef_idx  = idx;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= S_IDLE;
      num_q             <= '0;
      idx               <= '0;
      acc_sign_bit_cost <= '0;
      acc_suffix_bits   <= '0;
      acc_context_bits  <= '0;
      acc_level_case    <= '0;
      rate_vld          <= 1'b0;
      rate_idx          <= '0;
      rate_val          <= '0;
      cg_rate_total     <= '0;
      cg_sat            <= 1'b0;
    end else begin
      rate_vld <= 1'b0;
      if (state != S_IDLE && cg_abort) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (cg_start) begin
              num_q         <= n_clamp;
              idx           <= '0;
              cg_rate_total <= '0;
              cg_sat        <= 1'b0;
              state         <= (n_clamp == '0) ? S_FINISH : S_REQ;
            end
          end
          S_REQ: begin
            if (coef_vld) begin
              acc_sign_bit_cost <= coef_sign_bits;
              acc_suffix_bits   <= coef_suffix_bits;
              acc_context_bits  <= coef_ctx_bits;
              acc_level_case    <= coef_level_case;
              state             <= S_LAUNCH;
            end
          end
          S_LAUNCH: state <= S_WAIT;
          S_WAIT: begin
            if (acc_done) begin
              rate_val <= acc_irate;
              rate_idx <= idx;
              rate_vld <= 1'b1;
              if (sum_ext[TOT_W]) begin
                cg_rate_total <= '1;
                cg_sat        <= 1'b1;
              end else begin
                cg_rate_total <= sum_ext[TOT_W-1:0];
              end
              if (last_coef) begin
                state <= S_FINISH;
              end else begin
                idx   <= idx + IW'(1);
                state <= S_REQ;
              end
            end
          end
          S_FINISH: state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rdoq_rate_scheduler.sv
// Bench for rdoq_rate_scheduler: transaction-level model checked every cycle, directed
// scenarios with literal expectations, then randomized CGs with stalls, delays and aborts.
module tb_rdoq_rate_scheduler;
  localparam int NC = 16;
  localparam int RW = 32;
  localparam int TW = 36;
  localparam int TWB = 33;
  localparam logic [63:0] MAXA = (64'd1 << TW) - 64'd1;
  localparam logic [63:0] MAXB = (64'd1 << TWB) - 64'd1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          cg_start = 1'b0, cg_abort = 1'b0, coef_vld = 1'b0, acc_done = 1'b0;
  logic [4:0]    cg_num_coeff = '0;
  logic [RW-1:0] coef_sign_bits = '0, coef_suffix_bits = '0, coef_ctx_bits = '0, acc_irate = '0;
  logic [1:0]    coef_level_case = '0;

  logic          coef_req, acc_start, rate_vld, cg_sat, cg_done, busy;
  logic [3:0]    coef_idx, rate_idx;
  logic [RW-1:0] acc_sign_bit_cost, acc_suffix_bits, acc_context_bits, rate_val;
  logic [1:0]    acc_level_case;
  logic [TW-1:0] cg_rate_total;

  logic          b_coef_req, b_acc_start, b_rate_vld, b_sat, b_done, b_busy;
  logic [3:0]    b_coef_idx, b_rate_idx;
  logic [RW-1:0] b_acc_sign, b_acc_suf, b_acc_ctx, b_rate_val;
  logic [1:0]    b_acc_case;
  logic [TWB-1:0] b_total;

  rdoq_rate_scheduler #(.NUM_COEFF(NC), .RATE_W(RW), .TOT_W(TW)) dut (
    .clk(clk), .rst(rst), .cg_start(cg_start), .cg_num_coeff(cg_num_coeff), .cg_abort(cg_abort),
    .coef_req(coef_req), .coef_idx(coef_idx), .coef_vld(coef_vld),
    .coef_sign_bits(coef_sign_bits), .coef_suffix_bits(coef_suffix_bits),
    .coef_ctx_bits(coef_ctx_bits), .coef_level_case(coef_level_case),
    .acc_start(acc_start), .acc_sign_bit_cost(acc_sign_bit_cost), .acc_suffix_bits(acc_suffix_bits),
    .acc_context_bits(acc_context_bits), .acc_level_case(acc_level_case),
    .acc_irate(acc_irate), .acc_done(acc_done), .rate_vld(rate_vld), .rate_idx(rate_idx),
    .rate_val(rate_val), .cg_rate_total(cg_rate_total), .cg_sat(cg_sat), .cg_done(cg_done), .busy(busy)
  );

  rdoq_rate_scheduler #(.NUM_COEFF(NC), .RATE_W(RW), .TOT_W(TWB)) dut_b (
    .clk(clk), .rst(rst), .cg_start(cg_start), .cg_num_coeff(cg_num_coeff), .cg_abort(cg_abort),
    .coef_req(b_coef_req), .coef_idx(b_coef_idx), .coef_vld(coef_vld),
    .coef_sign_bits(coef_sign_bits), .coef_suffix_bits(coef_suffix_bits),
    .coef_ctx_bits(coef_ctx_bits), .coef_level_case(coef_level_case),
    .acc_start(b_acc_start), .acc_sign_bit_cost(b_acc_sign), .acc_suffix_bits(b_acc_suf),
    .acc_context_bits(b_acc_ctx), .acc_level_case(b_acc_case),
    .acc_irate(acc_irate), .acc_done(acc_done), .rate_vld(b_rate_vld), .rate_idx(b_rate_idx),
    .rate_val(b_rate_val), .cg_rate_total(b_total), .cg_sat(b_sat), .cg_done(b_done), .busy(b_busy)
  );

  // stimulus tables and responder knobs
  logic [RW-1:0] f_sign [NC];
  logic [RW-1:0] f_suf  [NC];
  logic [RW-1:0] f_ctx  [NC];
  logic [1:0]    f_case [NC];
  int stall_idx = -1, stall_left = 0, slow_idx = -1, slow_delay = 3;
  bit rand_mode = 1'b0;
  int cd = 0;
  logic [RW-1:0] pend_rate = '0;

  // observation logs
  logic [RW-1:0] log_rate [$];
  int log_idx [$];
  int n_rv = 0, n_req = 0, n_acc = 0, n_done = 0, last_launch_idx = -1;
  int cyc = 0, start_cyc = 0, done_cyc = 0;

  // behavioural model: one CG transaction, tracked as coefficient index plus progress step
  bit m_active = 1'b0, m_fin = 1'b0, m_rv = 1'b0, m_sat_a = 1'b0, m_sat_b = 1'b0;
  int m_n = 0, m_idx = 0, m_step = 0, m_ridx = 0;
  logic [RW-1:0] m_rate = '0, m_sign = '0, m_suf = '0, m_ctx = '0;
  logic [1:0] m_case = '0;
  logic [63:0] m_tot_a = '0, m_tot_b = '0;

  int total_n = 0, bad_n = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_n++;
    if (act !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [RW-1:0] acc_fn(input logic [RW-1:0] s, input logic [RW-1:0] u,
                                           input logic [RW-1:0] c, input logic [1:0] lc);
    return (lc == 2'd0) ? '0 : (s + u + c);
  endfunction

  task automatic model_reset();
    m_active = 0; m_fin = 0; m_rv = 0; m_sat_a = 0; m_sat_b = 0;
    m_n = 0; m_idx = 0; m_step = 0; m_ridx = 0;
    m_rate = '0; m_sign = '0; m_suf = '0; m_ctx = '0; m_case = '0;
    m_tot_a = '0; m_tot_b = '0; cd = 0;
  endtask

  task automatic model_step();
    logic [63:0] t;
    m_rv = 0;
    if (rst) begin
      model_reset();
    end else if (!m_active) begin
      if (cg_start) begin
        m_active = 1; m_idx = 0; m_step = 0;
        m_n = (int'(cg_num_coeff) > NC) ? NC : int'(cg_num_coeff);
        m_fin = (m_n == 0);
        m_tot_a = '0; m_tot_b = '0; m_sat_a = 0; m_sat_b = 0;
      end
    end else if (cg_abort) begin
      m_active = 0; cd = 0;
    end else if (m_fin) begin
      m_active = 0;
    end else if (m_step == 0) begin
      if (coef_vld) begin
        m_sign = coef_sign_bits; m_suf = coef_suffix_bits;
        m_ctx = coef_ctx_bits; m_case = coef_level_case; m_step = 1;
      end
    end else if (m_step == 1) begin
      m_step = 2;
    end else if (acc_done) begin
      m_rv = 1; m_rate = acc_irate; m_ridx = m_idx;
      t = m_tot_a + 64'(acc_irate);
      if (t > MAXA) begin t = MAXA; m_sat_a = 1; end
      m_tot_a = t;
      t = m_tot_b + 64'(acc_irate);
      if (t > MAXB) begin t = MAXB; m_sat_b = 1; end
      m_tot_b = t;
      if (m_idx == m_n - 1) m_fin = 1;
      else begin m_idx++; m_step = 0; end
    end
  endtask

  task automatic compare();
    bit exp_req;
    exp_req = m_active && !m_fin && m_step == 0 && !cg_abort;
    chk("busy", busy, m_active);
    chk("coef_req", coef_req, exp_req);
    if (exp_req) chk("coef_idx", coef_idx, m_idx);
    chk("acc_start", acc_start, m_active && !m_fin && m_step == 1 && !cg_abort);
    if (m_active && !m_fin && m_step != 0) begin
      chk("acc_sign", acc_sign_bit_cost, m_sign);
      chk("acc_suffix", acc_suffix_bits, m_suf);
      chk("acc_ctx", acc_context_bits, m_ctx);
      chk("acc_case", acc_level_case, m_case);
    end
    chk("cg_done", cg_done, m_active && m_fin && !cg_abort);
    chk("rate_vld", rate_vld, m_rv);
    if (m_rv) begin
      chk("rate_idx", rate_idx, m_ridx);
      chk("rate_val", rate_val, m_rate);
    end
    chk("cg_total", cg_rate_total, m_tot_a);
    chk("cg_sat", cg_sat, m_sat_a);
    chk("cg_total_w33", b_total, m_tot_b);
    chk("cg_sat_w33", b_sat, m_sat_b);
  endtask

  // environment: upstream/accumulator responders, per-cycle compare, model advance
  initial begin
    forever begin
      @(negedge clk);
      if (cd > 0) begin
        cd--;
        acc_done = (cd == 0);
        acc_irate = (cd == 0) ? pend_rate : $urandom;
      end else begin
        acc_done = 1'b0;
        acc_irate = $urandom;
      end
      coef_sign_bits   = f_sign[coef_idx];
      coef_suffix_bits = f_suf[coef_idx];
      coef_ctx_bits    = f_ctx[coef_idx];
      coef_level_case  = f_case[coef_idx];
      if (rand_mode) coef_vld = ($urandom_range(0, 3) != 0);
      else coef_vld = !(stall_left > 0 && int'(coef_idx) == stall_idx);
      #3;
      if (rst) model_reset();
      compare();
      if (rate_vld) begin log_rate.push_back(rate_val); log_idx.push_back(int'(rate_idx)); n_rv++; end
      if (coef_req) n_req++;
      if (cg_done) begin n_done++; done_cyc = cyc; end
      if (cg_start && !busy && !rst) start_cyc = cyc;
      if (coef_req && !coef_vld && int'(coef_idx) == stall_idx && stall_left > 0) stall_left--;
      if (acc_start) begin
        n_acc++;
        last_launch_idx = int'(coef_idx);
        pend_rate = acc_fn(acc_sign_bit_cost, acc_suffix_bits, acc_context_bits, acc_level_case);
        if (rand_mode) cd = $urandom_range(1, 4);
        else cd = (int'(coef_idx) == slow_idx) ? slow_delay : 1;
      end
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_logs();
    log_rate.delete(); log_idx.delete();
    n_rv = 0; n_req = 0; n_acc = 0; n_done = 0; last_launch_idx = -1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic start_cg(input int n, input bit with_abort);
    cg_start = 1'b1; cg_num_coeff = 5'(n); cg_abort = with_abort;
    tick();
    cg_start = 1'b0; cg_abort = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int budget);
    int k = 0;
    while (n_done == 0 && k < budget) begin tick(); k++; end
    if (n_done == 0) chk({nm, "_timeout"}, n_done, 1);
    tick();
  endtask

  task automatic wait_idle(input string nm, input int budget);
    int k = 0;
    while (busy && k < budget) begin tick(); k++; end
    if (busy) chk({nm, "_timeout"}, busy, 0);
    tick();
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_coef_req"}, coef_req, 0);   chk({nm, "_coef_idx"}, coef_idx, 0);
    chk({nm, "_acc_start"}, acc_start, 0); chk({nm, "_acc_sign"}, acc_sign_bit_cost, 0);
    chk({nm, "_acc_suf"}, acc_suffix_bits, 0); chk({nm, "_acc_ctx"}, acc_context_bits, 0);
    chk({nm, "_acc_case"}, acc_level_case, 0); chk({nm, "_rate_vld"}, rate_vld, 0);
    chk({nm, "_rate_idx"}, rate_idx, 0);   chk({nm, "_rate_val"}, rate_val, 0);
    chk({nm, "_total"}, cg_rate_total, 0); chk({nm, "_sat"}, cg_sat, 0);
    chk({nm, "_done"}, cg_done, 0);        chk({nm, "_busy"}, busy, 0);
  endtask

  task automatic load_t1();
    f_sign[0] = 1; f_suf[0] = 2; f_ctx[0] = 3; f_case[0] = 1;
    f_sign[1] = 1; f_suf[1] = 0; f_ctx[1] = 5; f_case[1] = 2;
    f_sign[2] = $urandom; f_suf[2] = $urandom; f_ctx[2] = $urandom; f_case[2] = 0;
    f_sign[3] = 1; f_suf[3] = 4; f_ctx[3] = 4; f_case[3] = 3;
  endtask

  task automatic load_random();
    for (int i = 0; i < NC; i++) begin
      f_sign[i] = $urandom_range(0, 4000); f_suf[i] = $urandom_range(0, 4000);
      f_ctx[i] = $urandom_range(0, 4000);  f_case[i] = 2'($urandom_range(0, 3));
    end
  endtask

  initial begin
    int exp1 [4] = '{6, 6, 0, 9};
    int r;
    bit sa;
    load_random();
    #1 rst = 1'b1;
    tick();
    check_all_zero("reset");
    tick();
    rst = 1'b0;
    tick();

    // four coefficients including a zero-level one
    load_t1(); clear_logs();
    start_cg(4, 0);
    wait_done("t1", 60);
    chk("t1_latency", done_cyc - start_cyc, 13);
    chk("t1_count", log_rate.size(), 4);
    for (int i = 0; i < 4 && i < log_rate.size(); i++) chk("t1_rate", log_rate[i], exp1[i]);
    chk("t1_total", cg_rate_total, 21);
    chk("t1_model_total", m_tot_a, 21);
    chk("t1_sat", cg_sat, 0);

    // empty CG
    clear_logs();
    start_cg(0, 0);
    wait_done("t2", 10);
    chk("t2_latency", done_cyc - start_cyc, 1);
    chk("t2_total", cg_rate_total, 0);
    chk("t2_req", n_req, 0);
    chk("t2_acc", n_acc, 0);
    chk("t2_rates", n_rv, 0);

    // full CG with an upstream stall and a slow accumulator reply
    load_random(); clear_logs();
    stall_idx = 7; stall_left = 5; slow_idx = 10; slow_delay = 3;
    start_cg(16, 0);
    wait_done("t3", 200);
    chk("t3_latency", done_cyc - start_cyc, 56);
    chk("t3_count", log_idx.size(), 16);
    for (int i = 0; i < 16 && i < log_idx.size(); i++) chk("t3_order", log_idx[i], i);
    stall_idx = -1; slow_idx = -1;

    // maximal rates: fits in 36 bits, clamps in 33 bits
    for (int i = 0; i < NC; i++) begin
      f_sign[i] = 32'hFFFF_FFFF; f_suf[i] = '0; f_ctx[i] = '0; f_case[i] = 2'd1;
    end
    clear_logs();
    start_cg(16, 0);
    wait_done("t4", 200);
    chk("t4_total36", cg_rate_total, 64'hF_FFFF_FFF0);
    chk("t4_sat36", cg_sat, 0);
    chk("t4_total33", b_total, 64'h1_FFFF_FFFF);
    chk("t4_sat33", b_sat, 1);

    // abort in WAIT of idx 2, coinciding with acc_done
    f_sign[0] = 1; f_suf[0] = 1; f_ctx[0] = 1; f_case[0] = 1;
    f_sign[1] = 2; f_suf[1] = 2; f_ctx[1] = 2; f_case[1] = 1;
    f_sign[2] = 5; f_suf[2] = 5; f_ctx[2] = 5; f_case[2] = 1;
    clear_logs();
    start_cg(4, 0);
    r = 0;
    while (last_launch_idx != 2 && r < 40) begin tick(); r++; end
    chk("t5_reached_idx2", last_launch_idx, 2);
    cg_abort = 1'b1;
    tick();
    cg_abort = 1'b0;
    chk("t5_busy", busy, 0);
    repeat (3) tick();
    chk("t5_rates", n_rv, 2);
    chk("t5_done", n_done, 0);
    chk("t5_partial", cg_rate_total, 9);
    clear_logs();
    start_cg(1, 0);
    chk("t5_cleared", cg_rate_total, 0);
    wait_done("t5b", 20);
    chk("t5b_total", cg_rate_total, 3);

    // reset during LAUNCH
    clear_logs();
    start_cg(3, 0);
    tick();
    chk("t6_in_launch", acc_start, 1);
    rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    tick();
    rst = 1'b0;
    repeat (4) tick();
    chk("t6_done", n_done, 0);

    // start while busy is ignored
    load_t1(); clear_logs();
    start_cg(4, 0);
    tick();
    cg_start = 1'b1; cg_num_coeff = 5'd1;
    tick();
    cg_start = 1'b0;
    wait_done("t7", 60);
    chk("t7_rates", n_rv, 4);
    chk("t7_total", cg_rate_total, 21);

    // randomized CGs: random counts (including >16), valid gaps, reply delays, aborts
    rand_mode = 1'b1;
    for (int it = 0; it < 40; it++) begin
      load_random(); clear_logs();
      sa = ($urandom_range(0, 7) == 0);
      start_cg($urandom_range(0, 20), sa);
      if ($urandom_range(0, 2) == 0) begin
        r = $urandom_range(0, 40);
        repeat (r) tick();
        cg_abort = 1'b1;
        tick();
        cg_abort = 1'b0;
      end
      wait_idle("rand", 600);
      for (int i = 0; i < log_idx.size(); i++) chk("rand_order", log_idx[i], i);
    end
    rand_mode = 1'b0;
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end

endmodule

// File: doc/rdoq_rate_scheduler.md
Name: rdoq_rate_scheduler

Overview:
Sequences the CABAC rate accumulator across one coefficient group (CG) for RDOQ. Per coefficient it fetches cost fields from the upstream estimator and launches the accumulator, then collects the per-coefficient iRate. It sums these rates into a saturating CG total. It sits between the coefficient-cost estimators and the RDOQ decision logic.

Parameters:
NUM_COEFF, 16, maximum coefficients per CG
RATE_W, 32, width of per-coefficient cost and rate fields
TOT_W, 36, width of CG rate total

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cg_start  in  1  start pulse, sampled only in IDLE
cg_num_coeff  in  $clog2(NUM_COEFF+1)  coefficients in CG, sampled with cg_start
cg_abort  in  1  abandon current CG
coef_req  out  1  request cost fields for coef_idx
coef_idx  out  $clog2(NUM_COEFF)  coefficient index being requested
coef_vld  in  1  cost fields valid; completes handshake when coef_req=1
coef_sign_bits  in  RATE_W  sign bit cost
coef_suffix_bits  in  RATE_W  suffix bits
coef_ctx_bits  in  RATE_W  context bits
coef_level_case  in  2  level case (0 = zero level)
acc_start  out  1  one-cycle launch to accumulator
acc_sign_bit_cost, acc_suffix_bits, acc_context_bits  out  RATE_W each  registered operands
acc_level_case  out  2  registered level case
acc_irate  in  RATE_W  accumulator result
acc_done  in  1  accumulator done pulse
rate_vld  out  1  one-cycle pulse: rate_val/rate_idx valid
rate_idx  out  $clog2(NUM_COEFF)  index of reported rate
rate_val  out  RATE_W  per-coefficient rate
cg_rate_total  out  TOT_W  CG rate sum, held until next accepted cg_start
cg_sat  out  1  sticky: total saturated in current CG
cg_done  out  1  one-cycle completion pulse
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0 and FSM in IDLE. Reset is asynchronous and takes priority everywhere. Asserting it mid-CG drops the CG silently, with no cg_done.
- FSM states: IDLE, REQ, LAUNCH, WAIT, FINISH.
- IDLE: on cg_start, latch N = min(cg_num_coeff, NUM_COEFF), clear idx, cg_rate_total and cg_sat.
  - N=0 goes to FINISH; otherwise goes to REQ.
  - cg_start outside IDLE is ignored.
- REQ: coef_req=1 with coef_idx=idx. On a cycle where coef_vld=1, register the four cost fields onto the acc_* outputs and go to LAUNCH. Stalls indefinitely while coef_vld=0.
- LAUNCH: acc_start=1 for exactly one cycle, then go to WAIT. acc_* operands are stable from LAUNCH through WAIT.
- WAIT: on acc_done=1, set rate_val=acc_irate and rate_idx=idx, and pulse rate_vld for one cycle. Add rate_val (zero-extended) to cg_rate_total.
  - If idx==N-1, go to FINISH; else increment idx and go to REQ.
  - acc_done outside WAIT is ignored.
- FINISH: cg_done=1 for one cycle, then go to IDLE.
- Level case 0 is still launched. The accumulator returns 0, and a zero rate is reported and summed normally.
- Latency: with coef_vld held high and acc_done one cycle after acc_start, each coefficient takes 3 cycles (REQ, LAUNCH, WAIT). cg_done asserts 3N+1 cycles after the cg_start cycle, and 1 cycle after it when N=0.
- Saturation: if the sum exceeds 2^TOT_W-1, cg_rate_total clamps to all-ones and cg_sat sets. Both hold until the next accepted cg_start.
- cg_abort in any non-IDLE state: go to IDLE next cycle, with no cg_done and no further rate_vld. coef_req and acc_start drop immediately. cg_rate_total keeps its partial value. cg_abort has priority over same-cycle coef_vld/acc_done.
- cg_abort in IDLE is ignored. Simultaneous cg_start and cg_abort in IDLE: start is accepted.
- Ordering: rate_vld pulses occur in index order 0..N-1, exactly once each.

Test Plan:
- N=4; costs (sign, suffix, ctx, case) = (1,2,3,1), (1,0,5,2), (x,x,x,0), (1,4,4,3); model accumulator replies after 1 cycle -> rate_val sequence 6, 6, 0, 9; cg_rate_total=21; cg_done 13 cycles after cg_start; cg_sat=0.
- cg_num_coeff=0 -> cg_done 1 cycle after start, total 0, no coef_req, no acc_start.
- N=16 with coef_vld deasserted 5 cycles at idx 7 and acc_done delayed 3 cycles at idx 10 -> all 16 rates reported in order, cg_done at cycle 3*16+1+5+2=56.
- TOT_W=36 and N=16, each rate 0xFFFFFFFF -> true sum 0xF_FFFF_FFF0 fits, cg_sat=0. Rerun with a bench TOT_W=33 -> total clamps to 0x1_FFFF_FFFF and cg_sat=1.
- cg_abort during WAIT of idx 2 while acc_done arrives the same cycle -> no rate_vld for idx 2, no cg_done, busy low next cycle. A new cg_start is then accepted and clears the total.
- rst asserted during LAUNCH -> all outputs 0 immediately. cg_start during busy (no rst) -> ignored, with unchanged N and total.
